// File: rtl/otter_intr_ctrl.sv
// Interrupt controller for the OTTER control FSM: synchronises and edge-detects
// the interrupt lines, latches pending events and runs the REQ/SERVICE handshake.
module otter_intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               ovf_clr,
  input  logic               int_taken,
  input  logic               mret,
  output logic               intr,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] ovf,
  output logic               in_service
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] dly_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] id_hot;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    id_d;
  logic               ack;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign eligible = pending & mask;
  assign id_hot   = NUM_SRC'(1) << int_id;
  assign clr      = ack ? id_hot : '0;

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = int_id;
    ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mie && (|eligible)) begin
          state_d = REQ;
          id_d    = sel;
        end
      end
      REQ: begin
        // Acknowledge beats withdrawal when both happen together
        if (int_taken) begin
          ack     = 1'b1;
          state_d = SERVICE;
        end else if (!mie || !(|(eligible & id_hot))) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      int_id  <= '0;
      pending <= '0;
      mask    <= '0;
      ovf     <= '0;
    end else begin
      state_q <= state_d;
      int_id  <= id_d;
      // A new edge re-arms the source even as its old event is acknowledged
      pending <= (pending & ~clr) | rise;
      ovf     <= (ovf_clr ? '0 : ovf) | (rise & pending & ~clr);
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign intr       = (state_q == REQ);
  assign in_service = (state_q == SERVICE);

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: reset, request/ack/mret, priority,
// withdrawal, overflow with set-wins, mie gating and async reset.
module tb_otter_intr_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [3:0] irq_src;
  logic       mie;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ovf_clr;
  logic       int_taken;
  logic       mret;
  logic       intr;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] ovf;
  logic       in_service;

  int tests = 0;
  int fails = 0;

  otter_intr_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .RST(RST), .irq_src(irq_src), .mie(mie),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .ovf_clr(ovf_clr),
    .int_taken(int_taken), .mret(mret), .intr(intr), .int_id(int_id),
    .pending(pending), .mask(mask), .ovf(ovf), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic ack();
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; irq_src = '0; mie = 1'b0; mask_we = 1'b0;
    mask_wdata = '0; ovf_clr = 1'b0; int_taken = 1'b0; mret = 1'b0;
    tick(2);
    RST = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      tests++;
      if ({intr, in_service, pending, mask, ovf} !== 14'd0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got intr=%b svc=%b pend=%h mask=%h ovf=%h want all 0",
                 c, intr, in_service, pending, mask, ovf);
      end
    end
  endtask

  task automatic test_basic();
    mie = 1'b1;
    set_mask(4'b0100);
    irq_src[2] = 1'b1;
    tick(2);
    tests++;
    if (pending !== 4'b0000) begin
      fails++; $display("FAIL basic_pend_e2 got %b want 0000", pending);
    end
    tick();
    tests++;
    if (pending !== 4'b0100 || intr !== 1'b0) begin
      fails++; $display("FAIL basic_pend_e3 got pend=%b intr=%b want 0100/0", pending, intr);
    end
    tick();
    tests++;
    if (intr !== 1'b1 || int_id !== 2'd2) begin
      fails++; $display("FAIL basic_req got intr=%b id=%0d want 1/2", intr, int_id);
    end
    ack();
    tests++;
    if (pending !== 4'b0 || in_service !== 1'b1 || intr !== 1'b0 || int_id !== 2'd2) begin
      fails++;
      $display("FAIL basic_ack got pend=%b svc=%b intr=%b id=%0d want 0000/1/0/2",
               pending, in_service, intr, int_id);
    end
    tick(3);
    tests++;
    if (in_service !== 1'b1 || intr !== 1'b0) begin
      fails++; $display("FAIL basic_hold got svc=%b intr=%b want 1/0", in_service, intr);
    end
    do_mret();
    tests++;
    if (in_service !== 1'b0 || intr !== 1'b0) begin
      fails++; $display("FAIL basic_mret got svc=%b intr=%b want 0/0", in_service, intr);
    end
    irq_src[2] = 1'b0;
    tick(4);
  endtask

  task automatic test_priority();
    set_mask(4'hF);
    irq_src[3] = 1'b1; irq_src[1] = 1'b1;
    tick(4);
    tests++;
    if (intr !== 1'b1 || int_id !== 2'd1 || pending !== 4'b1010) begin
      fails++;
      $display("FAIL prio_first got intr=%b id=%0d pend=%b want 1/1/1010", intr, int_id, pending);
    end
    ack();
    tests++;
    if (pending !== 4'b1000 || in_service !== 1'b1) begin
      fails++; $display("FAIL prio_ack got pend=%b svc=%b want 1000/1", pending, in_service);
    end
    do_mret();
    tests++;
    if (intr !== 1'b0) begin
      fails++; $display("FAIL prio_mret_idle got intr=%b want 0", intr);
    end
    tick();
    tests++;
    if (intr !== 1'b1 || int_id !== 2'd3) begin
      fails++; $display("FAIL prio_second got intr=%b id=%0d want 1/3", intr, int_id);
    end
    ack();
    do_mret();
    irq_src[3] = 1'b0; irq_src[1] = 1'b0;
    tick(4);
    tests++;
    if (pending !== 4'b0 || intr !== 1'b0) begin
      fails++; $display("FAIL prio_clean got pend=%b intr=%b want 0000/0", pending, intr);
    end
  endtask

  task automatic test_withdraw();
    irq_src[0] = 1'b1;
    tick(4);
    tests++;
    if (intr !== 1'b1 || int_id !== 2'd0) begin
      fails++; $display("FAIL wd_req got intr=%b id=%0d want 1/0", intr, int_id);
    end
    set_mask(4'h0);
    tick();
    tests++;
    if (intr !== 1'b0 || pending[0] !== 1'b1) begin
      fails++; $display("FAIL wd_drop got intr=%b pend=%b want 0/xxx1", intr, pending);
    end
    set_mask(4'h1);
    tick();
    tests++;
    if (intr !== 1'b1 || int_id !== 2'd0) begin
      fails++; $display("FAIL wd_restore got intr=%b id=%0d want 1/0", intr, int_id);
    end
    ack();
    do_mret();
    irq_src[0] = 1'b0;
    set_mask(4'hF);
    tick(3);
  endtask

  task automatic test_overflow();
    irq_src[1] = 1'b1; tick();
    irq_src[1] = 1'b0; tick();
    irq_src[1] = 1'b1; tick();
    irq_src[1] = 1'b0;
    tick(4);
    tests++;
    if (ovf !== 4'b0010 || intr !== 1'b1 || int_id !== 2'd1) begin
      fails++;
      $display("FAIL ovf_set got ovf=%b intr=%b id=%0d want 0010/1/1", ovf, intr, int_id);
    end
    irq_src[1] = 1'b1;
    tick(2);
    ack();
    tests++;
    if (pending[1] !== 1'b1 || in_service !== 1'b1 || ovf !== 4'b0010) begin
      fails++;
      $display("FAIL set_wins got pend=%b svc=%b ovf=%b want xx1x/1/0010",
               pending, in_service, ovf);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tests++;
    if (ovf !== 4'b0000) begin
      fails++; $display("FAIL ovf_clr got %b want 0000", ovf);
    end
    do_mret();
    tick();
    ack();
    do_mret();
    irq_src[1] = 1'b0;
    tick(3);
    tests++;
    if (pending !== 4'b0 || ovf !== 4'b0 || intr !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clean got pend=%b ovf=%b intr=%b want 0/0/0", pending, ovf, intr);
    end
  endtask

  task automatic test_gating_reset();
    mie = 1'b0;
    irq_src[0] = 1'b1;
    tick(3);
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (intr !== 1'b0 || pending !== 4'b0001) begin
        fails++;
        $display("FAIL gate_mie cyc=%0d got intr=%b pend=%b want 0/0001", c, intr, pending);
      end
    end
    mie = 1'b1;
    tick();
    tests++;
    if (intr !== 1'b1 || int_id !== 2'd0) begin
      fails++; $display("FAIL gate_enable got intr=%b id=%0d want 1/0", intr, int_id);
    end
    ack();
    irq_src[0] = 1'b0;
    tests++;
    if (in_service !== 1'b1) begin
      fails++; $display("FAIL gate_svc got svc=%b want 1", in_service);
    end
    RST = 1'b0;
    #2;
    tests++;
    if ({intr, in_service, pending, mask, ovf, int_id} !== 16'd0) begin
      fails++;
      $display("FAIL async_rst got intr=%b svc=%b pend=%b mask=%b ovf=%b id=%0d want all 0",
               intr, in_service, pending, mask, ovf, int_id);
    end
    #2;
    RST = 1'b1;
    tick(3);
    tests++;
    if ({intr, in_service, pending, mask, ovf} !== 14'd0) begin
      fails++;
      $display("FAIL post_rst got intr=%b svc=%b pend=%b mask=%b ovf=%b want all 0",
               intr, in_service, pending, mask, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_overflow();
    test_gating_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Interrupt controller that sits in front of the OTTER control-unit FSM.
- Synchronises several asynchronous interrupt lines, edge-detects them and latches pending events.
- Applies a per-source mask and the global CSR enable, then selects the highest-priority source.
- Drives the single `intr` input of the control FSM, completes the handshake on `int_taken`, and blocks further requests until `mret` retires the handler.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16); source 0 has the highest priority.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
- ID_W, $clog2(NUM_SRC) (1 when NUM_SRC=1), width of `int_id`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  asynchronous interrupt lines, rising-edge triggered.
- mie  in  1  global interrupt enable from the CSR file (mstatus.MIE).
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_SRC  new mask value; 1 = source enabled.
- ovf_clr  in  1  clears all overflow flags.
- int_taken  in  1  acknowledge from the control FSM.
- mret  in  1  one-cycle pulse when an MRET instruction executes.
- intr  out  1  interrupt request to the control FSM.
- int_id  out  ID_W  index of the requested or serviced source (for mcause).
- pending  out  NUM_SRC  latched pending events.
- mask  out  NUM_SRC  current mask register.
- ovf  out  NUM_SRC  sticky flag: an event arrived while that source was already pending.
- in_service  out  1  a handler is active.

Behaviour:
- **Reset (RST=0, asynchronous):**
  - Clears synchronisers, edge registers, pending, mask, ovf and int_id.
  - State = IDLE; intr=0, in_service=0.
  - Reset mid-handshake or mid-service drops all state; no event survives.
- **Input path:**
  - Each irq_src[i] passes through SYNC_STAGES flops, then a delay flop.
  - edge[i] = sync_out & ~sync_dly, combinational.
  - A line held high produces exactly one edge.
- **Pending register:**
  - Set: an edge sets pending[i] on the next clock.
  - Clear: the ack (int_taken in REQ) clears pending[int_id].
  - Set and clear on the same source in the same cycle: set wins.
  - Overflow: an edge on a source whose pending is already 1 (and not being cleared) sets ovf[i].
  - ovf_clr zeroes ovf; an overflow event in the same cycle wins.
- **Mask:** loaded from mask_wdata when mask_we=1. It has no effect on pending latching.
- **Selection:** eligible = pending & mask; sel = lowest set index of eligible. Combinational.
- **State machine (registered):**
  - IDLE:
    - intr=0.
    - If mie=1 and eligible≠0: latch int_id←sel and go to REQ.
  - REQ:
    - intr=1; int_id frozen.
    - If int_taken=1: clear pending[int_id] and go to SERVICE.
    - Else if mie=0 or eligible[int_id]=0 (masked off): go to IDLE; intr drops next cycle.
    - int_taken has priority over withdrawal in the same cycle.
    - A higher-priority source arriving during REQ does not pre-empt the latched id.
  - SERVICE:
    - intr=0, in_service=1; int_id holds the serviced source.
    - mret=1: go to IDLE.
    - No nesting: new events only latch as pending.
  - mret outside SERVICE is ignored.
  - int_taken outside REQ is ignored.
- **Latency:**
  - irq_src rising (setup met) → pending set at edge SYNC_STAGES+1.
  - intr high after edge SYNC_STAGES+2.
  - mret → IDLE in 1 cycle; a still-eligible source re-raises intr one cycle later.
- **Outputs:** all outputs are registered-state-derived, with no combinational path from any input to intr.

Test Plan:
- **Reset and idle:** RST low, then high; toggle nothing → intr=0, pending=0, mask=0, ovf=0, in_service=0 for 20 cycles.
- **Basic request:** mask=4'b0100, mie=1; pulse irq_src[2] → pending=4'b0100 at edge 3, intr=1 after edge 4, int_id=2. Then int_taken=1 for one cycle → pending=0, in_service=1, intr=0. Then mret → in_service=0.
- **Priority:** mask=4'hF; raise irq_src[3] and irq_src[1] on the same cycle → int_id=1. After ack and mret → intr re-asserts with int_id=3.
- **Withdrawal:** in REQ for source 0, write mask=0 → intr=0 next cycle, pending[0] still 1. Restore mask=4'h1 → intr=1 again, int_id=0.
- **Overflow and set-wins:** two edges on irq_src[1] before ack → ovf=4'b0010. Then an edge arriving in the int_taken cycle for id 1 → pending[1] stays 1. ovf_clr → ovf=0.
- **Gating and async reset:** mie=0 with pending=4'h1 → intr stays 0. In SERVICE, pulse RST low for a partial cycle → immediate IDLE, all outputs 0.
